// File: rtl/lfsr_prng_pkg.sv
// lfsr_pkg: shared types and constants for the lfsr_prng word source.
// Provides the FSM state enum and maximal-length tap masks per width.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } lfsr_state_e;

    // Tap masks for a left-shifting Fibonacci register, fb into bit 0.
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;
    localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/lfsr_prng_if.sv
// lfsr_prng_if: seed-load and word-output handshakes of lfsr_prng.
// master = generator side, slave = seed source / word consumer side.
interface lfsr_prng_if #(
    parameter int WIDTH = 32
);

    logic             enable;
    logic             seed_valid;
    logic [WIDTH-1:0] seed_data;
    logic             seed_ready;
    logic             random_seed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             reseed_req;
    logic             lockup;

    modport master (
        input  enable,
        input  seed_valid,
        input  seed_data,
        input  random_seed,
        input  out_ready,
        output seed_ready,
        output out_valid,
        output out_data,
        output reseed_req,
        output lockup
    );

    modport slave (
        output enable,
        output seed_valid,
        output seed_data,
        output random_seed,
        output out_ready,
        input  seed_ready,
        input  out_valid,
        input  out_data,
        input  reseed_req,
        input  lockup
    );

endinterface

// File: rtl/lfsr_prng_step.sv
// lfsr_step: one combinational Fibonacci shift of the LFSR state.
// Ports: state_i (current), inject_i (extra fb bit), state_o (shifted).
module lfsr_step #(
    parameter int WIDTH = 32,
    parameter     TAPS  = 32'h8020_0003
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic             inject_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [WIDTH-1:0] MASK = WIDTH'(TAPS);

    logic fb;

    assign fb      = (^(state_i & MASK)) ^ inject_i;
    assign state_o = {state_i[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_prng.sv
// lfsr_prng: Fibonacci LFSR word source with seed load, valid/ready
// output, STEPS shifts per word, lock-up recovery and reseed interval.
// Ports: clk, rst (async, active high), bus (lfsr_prng_if.master).
// Build option: define LFSR_ENTROPY_MIX_EN to XOR random_seed into the
// feedback of the first shift of every advance.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter     TAPS            = 32'h8020_0003,
    parameter int STEPS           = 1,
    parameter     DEFAULT_SEED    = 1,
    parameter int RESEED_INTERVAL = 1024
) (
    input  logic        clk,
    input  logic        rst,
    lfsr_prng_if.master bus
);

    localparam logic [WIDTH-1:0] SEED0 = WIDTH'(DEFAULT_SEED);
    localparam int CW = (RESEED_INTERVAL > 0) ?
                        $clog2(RESEED_INTERVAL + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_LIM = CW'(RESEED_INTERVAL);
    localparam bit LIMIT_ON = (RESEED_INTERVAL != 0);

    lfsr_state_e      fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lockup_q, lockup_d;

    logic             ent;
    logic             adv;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] next_w;
    logic [WIDTH-1:0] chain [0:STEPS];

`ifdef LFSR_ENTROPY_MIX_EN
    assign ent = bus.random_seed;
`else
    logic unused_entropy;
    assign unused_entropy = bus.random_seed;
    assign ent = 1'b0;
`endif

    // STEPS single-bit shifts chained within one cycle.
    assign chain[0] = state_q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .state_i  (chain[g]),
            .inject_i ((g == 0) ? ent : 1'b0),
            .state_o  (chain[g+1])
        );
    end

    assign next_w  = chain[STEPS];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        lockup_d = 1'b0;
        adv      = 1'b0;

        unique case (fsm_q)
            IDLE: begin
                if (bus.enable) fsm_d = RUN;
            end
            RUN: begin
                if (!bus.enable) begin
                    fsm_d = IDLE;
                end else if (bus.out_ready) begin
                    adv   = 1'b1;
                    cnt_d = cnt_inc;
                    if (LIMIT_ON && cnt_inc == CNT_LIM) fsm_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.seed_valid) fsm_d = bus.enable ? RUN : IDLE;
            end
            default: fsm_d = IDLE;
        endcase

        if (adv) begin
            if (next_w == '0) begin
                state_d  = SEED0;
                lockup_d = 1'b1;
            end else begin
                state_d = next_w;
            end
        end

        // A seed beats a same-cycle advance; the old word still counts
        // as delivered but the count restarts from zero.
        if (bus.seed_valid) begin
            state_d  = (bus.seed_data == '0) ? SEED0 : bus.seed_data;
            cnt_d    = '0;
            lockup_d = 1'b0;
            if (fsm_q == RUN && fsm_d == HOLD) fsm_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= IDLE;
            state_q  <= SEED0;
            cnt_q    <= '0;
            lockup_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lockup_q <= lockup_d;
        end
    end

    assign bus.out_valid  = (fsm_q == RUN);
    assign bus.seed_ready = 1'b1;
    assign bus.reseed_req = (fsm_q == HOLD);
    assign bus.lockup     = lockup_q;
    assign bus.out_data   = state_q;

endmodule
